// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
//
// Walks a note chart one entry per beat and keeps a fixed pool of falling
// note slots for the renderer. Each lane owns SLOTS slots. On every frame tick
// while a song is running, live notes move down the screen. A note that
// reaches SCREEN_H is retired and reported on `miss`. A hit request takes the
// lowest on-screen note inside the hit window and reports it on `hit_ok`.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        pulse: begin a song (honoured only in IDLE/DONE)
//   frame_tick   one-cycle pulse per displayed frame
//   chart_addr   chart ROM address (6 bits)
//   chart_data   chart ROM lane mask, valid one cycle after chart_addr
//   hit_req      per-lane hit pulse from the judge
//   note_valid   slot valid bits, slot s of lane l at index l*SLOTS+s
//   note_y       10-bit slot y positions, same indexing as note_valid
//   hit_ok       per-lane pulse, one cycle after a successful hit
//   miss         per-lane pulse, one cycle after a note was retired unhit
//   busy         song in progress (WAIT_BEAT, FETCH, SPAWN, DRAIN)
//   done         song finished
//   overflow     sticky: a chart note was dropped because its lane was full
// ---------------------------------------------------------------------------
module note_sequencer #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned SLOTS       = 4,
    parameter int unsigned CHART_LEN   = 63,
    parameter int unsigned BEAT_FRAMES = 30,
    parameter int unsigned NOTE_SPEED  = 2,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned HIT_Y       = 350,
    parameter int unsigned HIT_H       = 20,
    parameter int unsigned NOTE_H      = 50
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        frame_tick,
    output logic [5:0]                  chart_addr,
    input  logic [LANES-1:0]            chart_data,
    input  logic [LANES-1:0]            hit_req,
    output logic [LANES*SLOTS-1:0]      note_valid,
    output logic [LANES*SLOTS*10-1:0]   note_y,
    output logic [LANES-1:0]            hit_ok,
    output logic [LANES-1:0]            miss,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int unsigned NumSlots = LANES * SLOTS;
    localparam int unsigned BeatW    = (BEAT_FRAMES > 1) ? $clog2(BEAT_FRAMES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitBeat,
        StFetch,
        StSpawn,
        StDrain,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [BeatW-1:0]     beat_q, beat_d;
    logic [5:0]           addr_q, addr_d;
    logic [NumSlots-1:0]  valid_q, valid_d;
    logic [9:0]           y_q [NumSlots];
    logic [9:0]           y_d [NumSlots];
    logic [LANES-1:0]     hit_ok_q, hit_ok_d;
    logic [LANES-1:0]     miss_q, miss_d;
    logic                 overflow_q, overflow_d;

    logic                 busy_s;
    logic [NumSlots-1:0]  in_win;
    logic [NumSlots-1:0]  hit_sel;

    assign busy_s = (state_q == StWaitBeat) || (state_q == StFetch) ||
                    (state_q == StSpawn)    || (state_q == StDrain);

    // Hit window test on the current (pre-motion) y; 11 bits so y+NOTE_H
    // cannot wrap.
    always_comb begin
        in_win = '0;
        for (int i = 0; i < NumSlots; i++) begin
            in_win[i] = valid_q[i] &&
                        (({1'b0, y_q[i]} + 11'(NOTE_H)) > 11'(HIT_Y)) &&
                        ({1'b0, y_q[i]} < 11'(HIT_Y + HIT_H));
        end
    end

    // Per lane, pick the in-window slot with the largest y. The strict '>'
    // keeps the lowest index on ties.
    always_comb begin : p_hit_sel
        logic       found;
        logic [9:0] best_y;
        int         best_s;
        hit_sel = '0;
        found   = 1'b0;
        best_y  = '0;
        best_s  = 0;
        for (int l = 0; l < LANES; l++) begin
            found  = 1'b0;
            best_y = '0;
            best_s = 0;
            for (int s = 0; s < SLOTS; s++) begin
                if (in_win[l*SLOTS+s] && (!found || (y_q[l*SLOTS+s] > best_y))) begin
                    found  = 1'b1;
                    best_y = y_q[l*SLOTS+s];
                    best_s = s;
                end
            end
            if (found && hit_req[l]) begin
                hit_sel[l*SLOTS+best_s] = 1'b1;
            end
        end
    end

    always_comb begin : p_next
        logic [9:0]  y_next;
        logic        free_seen;
        int unsigned idx;

        state_d    = state_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        y_d        = y_q;
        hit_ok_d   = '0;
        miss_d     = '0;
        overflow_d = overflow_q;
        y_next     = '0;
        free_seen  = 1'b0;
        idx        = 0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    valid_d    = '0;
                    y_d        = '{default: '0};
                    overflow_d = 1'b0;
                    beat_d     = '0;
                    addr_d     = '0;
                    state_d    = StWaitBeat;
                end
            end
            StWaitBeat: begin
                if (frame_tick) begin
                    if (beat_q == BeatW'(BEAT_FRAMES - 1)) begin
                        beat_d  = '0;
                        state_d = StFetch;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            // chart_addr is stable here so the ROM data is ready in SPAWN.
            StFetch: begin
                state_d = StSpawn;
            end
            StSpawn: begin
                if (addr_q == 6'(CHART_LEN - 1)) begin
                    state_d = StDrain;
                end else begin
                    addr_d  = addr_q + 6'd1;
                    state_d = StWaitBeat;
                end
            end
            StDrain: begin
                if (valid_q == '0) begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Live slots move/retire/get hit; free slots may take a new note.
        // Both act on the start-of-cycle valid bits, so they never collide,
        // and a freshly spawned slot stays at y=0 even on a frame tick.
        if (busy_s) begin
            for (int l = 0; l < LANES; l++) begin
                free_seen = 1'b0;
                for (int s = 0; s < SLOTS; s++) begin
                    idx = l * SLOTS + s;
                    if (valid_q[idx]) begin
                        y_next = frame_tick ? (y_q[idx] + 10'(NOTE_SPEED)) : y_q[idx];
                        if (hit_sel[idx]) begin
                            // A hit beats a retire on the same cycle.
                            valid_d[idx] = 1'b0;
                            y_d[idx]     = '0;
                            hit_ok_d[l]  = 1'b1;
                        end else if (frame_tick && ({1'b0, y_next} >= 11'(SCREEN_H))) begin
                            valid_d[idx] = 1'b0;
                            y_d[idx]     = '0;
                            miss_d[l]    = 1'b1;
                        end else begin
                            y_d[idx] = y_next;
                        end
                    end else if (!free_seen) begin
                        free_seen = 1'b1;
                        if ((state_q == StSpawn) && chart_data[l]) begin
                            valid_d[idx] = 1'b1;
                            y_d[idx]     = '0;
                        end
                    end
                end
                if ((state_q == StSpawn) && chart_data[l] && !free_seen) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            addr_q     <= '0;
            valid_q    <= '0;
            y_q        <= '{default: '0};
            hit_ok_q   <= '0;
            miss_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            y_q        <= y_d;
            hit_ok_q   <= hit_ok_d;
            miss_q     <= miss_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        note_y = '0;
        for (int i = 0; i < NumSlots; i++) begin
            note_y[i*10 +: 10] = y_q[i];
        end
    end

    assign chart_addr = addr_q;
    assign note_valid = valid_q;
    assign hit_ok     = hit_ok_q;
    assign miss       = miss_q;
    assign overflow   = overflow_q;
    assign busy       = busy_s;
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer. Three instances share clk/reset/frame_tick/hit_req:
//   dut_a  default parameters, driven by a vector table (start_a)
//   dut_b  BEAT_FRAMES=1, CHART_LEN=8, lane-3 overflow scenario (start_bc)
//   dut_c  BEAT_FRAMES=1, CHART_LEN=2, short screen so the hit window
//          overlaps the retire line (start_bc)
module tb_note_sequencer;

    logic         clk;
    logic         reset;
    logic         start_a;
    logic         start_bc;
    logic         frame_tick;
    logic [3:0]   hit_req;

    logic [5:0]   a_addr, b_addr, c_addr;
    logic [3:0]   a_data, b_data, c_data;
    logic [15:0]  a_valid, b_valid, c_valid;
    logic [159:0] a_y, b_y, c_y;
    logic [3:0]   a_hok, b_hok, c_hok;
    logic [3:0]   a_miss, b_miss, c_miss;
    logic         a_busy, b_busy, c_busy;
    logic         a_done, b_done, c_done;
    logic         a_ovf, b_ovf, c_ovf;

    logic [3:0]   rom_a [64];
    logic [3:0]   rom_b [64];

    int n_cmp;
    int n_bad;

    logic [3:0] acc_miss, acc_hok;
    logic [3:0] cap_b_hok, cap_c_hok, cap_c_miss;

    note_sequencer dut_a (
        .clk(clk), .reset(reset), .start(start_a), .frame_tick(frame_tick),
        .chart_addr(a_addr), .chart_data(a_data), .hit_req(hit_req),
        .note_valid(a_valid), .note_y(a_y), .hit_ok(a_hok), .miss(a_miss),
        .busy(a_busy), .done(a_done), .overflow(a_ovf)
    );

    note_sequencer #(.BEAT_FRAMES(1), .CHART_LEN(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_bc), .frame_tick(frame_tick),
        .chart_addr(b_addr), .chart_data(b_data), .hit_req(hit_req),
        .note_valid(b_valid), .note_y(b_y), .hit_ok(b_hok), .miss(b_miss),
        .busy(b_busy), .done(b_done), .overflow(b_ovf)
    );

    note_sequencer #(.BEAT_FRAMES(1), .CHART_LEN(2), .SCREEN_H(100), .HIT_Y(90),
                     .HIT_H(20), .NOTE_H(10)) dut_c (
        .clk(clk), .reset(reset), .start(start_bc), .frame_tick(frame_tick),
        .chart_addr(c_addr), .chart_data(c_data), .hit_req(hit_req),
        .note_valid(c_valid), .note_y(c_y), .hit_ok(c_hok), .miss(c_miss),
        .busy(c_busy), .done(c_done), .overflow(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chart ROMs with one cycle of read latency.
    always @(posedge clk) begin
        a_data <= rom_a[a_addr];
        b_data <= rom_b[b_addr];
        c_data <= rom_b[c_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] ysel(input logic [159:0] v, input int i);
        return v[i*10 +: 10];
    endfunction

    // One cycle on dut_a, collecting any pulses seen.
    task automatic cyc_a();
        @(negedge clk);
        acc_miss = acc_miss | a_miss;
        acc_hok  = acc_hok | a_hok;
    endtask

    // One frame period (4 cycles) for dut_b/dut_c; pulses captured right
    // after the driven cycle.
    task automatic pulse(input logic t, input logic [3:0] h);
        frame_tick = t;
        hit_req    = h;
        @(negedge clk);
        cap_b_hok  = b_hok;
        cap_c_hok  = c_hok;
        cap_c_miss = c_miss;
        frame_tick = 1'b0;
        hit_req    = '0;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int          ticks;     // frame ticks to apply (hit rides on the last)
        logic [3:0]  hit;
        logic [15:0] valid;     // expected note_valid afterwards
        logic [3:0]  miss;      // expected OR of miss pulses during the step
        logic [3:0]  hok;       // expected OR of hit_ok pulses during the step
        int          yidx;      // slot whose y is probed
        logic [9:0]  y;
    } vec_t;

    vec_t vecs [13];
    logic [15:0] exp_bv [5];

    initial begin
        int ticks_bc;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start_a = 1'b0;
        start_bc = 1'b0;
        frame_tick = 1'b0;
        hit_req = '0;
        acc_miss = '0;
        acc_hok = '0;
        cap_b_hok = '0;
        cap_c_hok = '0;
        cap_c_miss = '0;
        for (int i = 0; i < 64; i++) begin
            rom_a[i] = '0;
            rom_b[i] = '0;
        end
        rom_a[0] = 4'b0001;
        rom_a[1] = 4'b0100;
        rom_a[2] = 4'b1111;
        rom_a[3] = 4'b0011;
        rom_a[4] = 4'b1100;
        for (int i = 0; i < 5; i++) rom_b[i] = 4'b1000;

        // Ticks counted from start; a note spawned at tick T has y = 2*(now-T).
        vecs[0]  = '{30, 4'b0000, 16'h0001, 4'b0000, 4'b0000, 0, 10'd0};
        vecs[1]  = '{30, 4'b0000, 16'h0101, 4'b0000, 4'b0000, 0, 10'd60};
        vecs[2]  = '{30, 4'b0000, 16'h1313, 4'b0000, 4'b0000, 0, 10'd120};
        vecs[3]  = '{30, 4'b0000, 16'h1337, 4'b0000, 4'b0000, 8, 10'd120};
        vecs[4]  = '{30, 4'b0000, 16'h3737, 4'b0000, 4'b0000, 1, 10'd120};
        vecs[5]  = '{60, 4'b0000, 16'h3737, 4'b0000, 4'b0000, 8, 10'd300};
        vecs[6]  = '{0,  4'b0100, 16'h3737, 4'b0000, 4'b0000, 8, 10'd300};
        vecs[7]  = '{10, 4'b0000, 16'h3737, 4'b0000, 4'b0000, 8, 10'd320};
        vecs[8]  = '{0,  4'b0100, 16'h3637, 4'b0000, 4'b0100, 9, 10'd260};
        vecs[9]  = '{49, 4'b0000, 16'h3637, 4'b0000, 4'b0000, 0, 10'd478};
        vecs[10] = '{1,  4'b0000, 16'h3636, 4'b0001, 4'b0000, 1, 10'd360};
        vecs[11] = '{2,  4'b0000, 16'h3636, 4'b0000, 4'b0000, 2, 10'd304};
        vecs[12] = '{0,  4'b0011, 16'h3624, 4'b0000, 4'b0011, 5, 10'd304};

        exp_bv[0] = 16'h1000;
        exp_bv[1] = 16'h3000;
        exp_bv[2] = 16'h7000;
        exp_bv[3] = 16'hF000;
        exp_bv[4] = 16'hF000;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        chk("rst_valid", 32'(a_valid), 32'h0);
        chk("rst_y", 32'(a_y == '0), 32'h1);
        chk("rst_addr", 32'(a_addr), 32'h0);
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_done", 32'(a_done), 32'h0);
        chk("rst_ovf", 32'(a_ovf), 32'h0);
        chk("rst_pulses", 32'({a_hok, a_miss}), 32'h0);

        // ---- Phase 1: dut_a table ----
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_start_busy", 32'(a_busy), 32'h1);
        chk("a_start_done", 32'(a_done), 32'h0);

        for (int i = 0; i < 13; i++) begin
            acc_miss = '0;
            acc_hok  = '0;
            for (int k = 0; k < vecs[i].ticks - 1; k++) begin
                frame_tick = 1'b1;
                cyc_a();
                frame_tick = 1'b0;
                repeat (3) cyc_a();
            end
            frame_tick = (vecs[i].ticks > 0);
            hit_req    = vecs[i].hit;
            cyc_a();
            frame_tick = 1'b0;
            hit_req    = '0;
            repeat (3) cyc_a();
            chk($sformatf("v%0d_valid", i), 32'(a_valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d_miss", i), 32'(acc_miss), 32'(vecs[i].miss));
            chk($sformatf("v%0d_hit_ok", i), 32'(acc_hok), 32'(vecs[i].hok));
            chk($sformatf("v%0d_y%0d", i, vecs[i].yidx), 32'(ysel(a_y, vecs[i].yidx)),
                32'(vecs[i].y));
        end
        chk("a_ovf_clear", 32'(a_ovf), 32'h0);
        chk("a_busy_mid", 32'(a_busy), 32'h1);

        // Reset mid-song with 6 notes live, plus a tick and an in-window hit.
        reset = 1'b1;
        frame_tick = 1'b1;
        hit_req = 4'b0100;
        @(negedge clk);
        reset = 1'b0;
        frame_tick = 1'b0;
        hit_req = '0;
        chk("mid_rst_valid", 32'(a_valid), 32'h0);
        chk("mid_rst_y", 32'(a_y == '0), 32'h1);
        chk("mid_rst_addr", 32'(a_addr), 32'h0);
        chk("mid_rst_pulses", 32'({a_hok, a_miss}), 32'h0);
        chk("mid_rst_flags", 32'({a_busy, a_done, a_ovf}), 32'h0);
        @(negedge clk);
        chk("mid_rst_pulses2", 32'({a_hok, a_miss}), 32'h0);

        // ---- Phase 2: dut_b overflow, dut_c hit-vs-retire and completion ----
        start_bc = 1'b1;
        @(negedge clk);
        start_bc = 1'b0;
        chk("bc_busy", 32'({b_busy, c_busy, c_done}), 32'b110);
        ticks_bc = 0;

        for (int k = 0; k < 5; k++) begin
            pulse(1'b1, 4'b0000);
            ticks_bc++;
            chk($sformatf("b_valid_t%0d", ticks_bc), 32'(b_valid), 32'(exp_bv[k]));
            chk($sformatf("b_ovf_t%0d", ticks_bc), 32'(b_ovf), 32'(k == 4));
        end
        chk("b_y12_t5", 32'(ysel(b_y, 12)), 32'd8);
        chk("c_valid_t5", 32'(c_valid), 32'h3000);
        chk("c_addr_drain", 32'(c_addr), 32'h1);

        while (ticks_bc < 50) begin
            pulse(1'b1, 4'b0000);
            ticks_bc++;
        end
        chk("c_y12_t50", 32'(ysel(c_y, 12)), 32'd98);
        chk("c_y13_t50", 32'(ysel(c_y, 13)), 32'd96);
        chk("b_ovf_sticky", 32'(b_ovf), 32'h1);

        // Hit on the very tick that would retire slot 12.
        pulse(1'b1, 4'b1000);
        ticks_bc++;
        chk("c_hit_vs_retire_ok", 32'(cap_c_hok), 32'b1000);
        chk("c_hit_vs_retire_miss", 32'(cap_c_miss), 32'h0);
        chk("b_hit_outside", 32'(cap_b_hok), 32'h0);
        chk("c_valid_t51", 32'(c_valid), 32'h2000);
        chk("c_y13_t51", 32'(ysel(c_y, 13)), 32'd98);

        // Last retire, then done one cycle later.
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        ticks_bc++;
        chk("c_last_miss", 32'(c_miss), 32'b1000);
        chk("c_done_early", 32'({c_busy, c_done}), 32'b10);
        @(negedge clk);
        chk("c_done", 32'({c_busy, c_done}), 32'b01);
        chk("c_miss_single", 32'(c_miss), 32'h0);
        repeat (2) @(negedge clk);
        chk("c_valid_done", 32'(c_valid), 32'h0);
        chk("c_addr_done", 32'(c_addr), 32'h1);

        // Restart: dut_c clears and runs, dut_b (still busy) ignores start.
        start_bc = 1'b1;
        @(negedge clk);
        start_bc = 1'b0;
        chk("c_restart_flags", 32'({c_busy, c_done, c_ovf}), 32'b100);
        chk("c_restart_addr", 32'(c_addr), 32'h0);
        chk("b_ignores_start", 32'({b_busy, b_ovf}), 32'b11);

        for (int n = 0; n < 300 && !b_done; n++) begin
            pulse(1'b1, 4'b0000);
            ticks_bc++;
        end
        chk("b_done", 32'(b_done), 32'h1);
        chk("b_done_tick", 32'(ticks_bc), 32'd244);
        chk("b_ovf_at_done", 32'(b_ovf), 32'h1);

        start_bc = 1'b1;
        @(negedge clk);
        start_bc = 1'b0;
        chk("b_ovf_cleared", 32'({b_busy, b_ovf}), 32'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
